// File: rtl/mutex_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mutex_arb_pkg
//  Brief    : Shared state encoding and owner constants for the two-requester
//             mutual-exclusion arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mutex_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        GAP     = 2'd3
    } arb_state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // Round-robin tie break: the side that did not own the resource last wins.
    function automatic logic tie_winner(input logic last_owner);
        return ~last_owner;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mutex_grant_arbiter_timer.sv
`default_nettype none
// ============================================================================
//  Module   : arb_hold_timer
//  Brief    : Up counter with synchronous clear, count enable and a
//             terminal-count flag compared against a run-time limit.
//             Used both as the hold-limit timer and the release gap timer.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_hold_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] tc_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // Clear has priority over counting so a state change always restarts at 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    // Terminal count: the counter has reached the programmed last value.
    assign tc = (count == tc_value);

endmodule
`default_nettype wire

// File: rtl/mutex_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mutex_grant_arbiter
//  Brief    : Two-requester arbiter with mutually exclusive registered grants,
//             round-robin tie break, hold-limit preemption and a mandatory
//             idle gap between every release and the next grant.
//  Config   : define MUTEX_ASSERT_EN to compile in a clocked simulation
//             checker and grant counters (ports/behaviour unchanged).
//  Revision : 1.0 - initial release
// ============================================================================
module mutex_grant_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic owner,
    output logic preempt
);

    import mutex_arb_pkg::*;

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int GAP_W  = $clog2(GAP + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);
    // The enum literal GAP is shadowed by the parameter of the same name.
    localparam arb_state_t ST_GAP = mutex_arb_pkg::GAP;

    arb_state_t state;
    arb_state_t next_state;
    logic       last_owner;
    logic       pend_a;
    logic       pend_b;
    logic       eff_a;
    logic       eff_b;
    logic       own_req;
    logic       other_req;
    logic       forced;
    logic       state_change;
    logic       hold_tc;
    logic       gap_tc;

    // Next-state decision: tie break in IDLE, release/preempt in GRANT, gap exit.
    always_comb begin
        eff_a      = req_a | pend_a;
        eff_b      = req_b | pend_b;
        own_req    = 1'b0;
        other_req  = 1'b0;
        forced     = 1'b0;
        next_state = state;
        case (state)
            IDLE: begin
                if (eff_a && eff_b) begin
                    next_state = (tie_winner(last_owner) == OWNER_A) ? GRANT_A : GRANT_B;
                end else if (eff_a) begin
                    next_state = GRANT_A;
                end else if (eff_b) begin
                    next_state = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                own_req   = (state == GRANT_A) ? req_a : req_b;
                other_req = (state == GRANT_A) ? req_b : req_a;
                if (!own_req) begin
                    next_state = ST_GAP;
                end else if (other_req && hold_tc) begin
                    next_state = ST_GAP;
                    forced     = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_tc) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        state_change = (next_state != state);
    end

    // Hold timer only advances while the other side is waiting; it stays at 0
    // for an uncontested owner so that owner may hold indefinitely.
    arb_hold_timer #(
        .WIDTH (HOLD_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_change | ~other_req),
        .en       (other_req),
        .tc_value (HOLD_LAST),
        .tc       (hold_tc)
    );

    arb_hold_timer #(
        .WIDTH (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_change),
        .en       (state == ST_GAP),
        .tc_value (GAP_LAST),
        .tc       (gap_tc)
    );

    // FSM state, round-robin bit, pending requests and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            busy       <= 1'b0;
            preempt    <= 1'b0;
            last_owner <= OWNER_B;
            pend_a     <= 1'b0;
            pend_b     <= 1'b0;
        end else begin
            state   <= next_state;
            gnt_a   <= (next_state == GRANT_A);
            gnt_b   <= (next_state == GRANT_B);
            busy    <= (next_state == GRANT_A) || (next_state == GRANT_B);
            preempt <= forced;
            if (state_change && next_state == GRANT_A) begin
                last_owner <= OWNER_A;
            end else if (state_change && next_state == GRANT_B) begin
                last_owner <= OWNER_B;
            end
            // Requests seen during the gap are remembered until served.
            if (state == ST_GAP) begin
                pend_a <= pend_a | req_a;
                pend_b <= pend_b | req_b;
            end else if (state == IDLE) begin
                if (next_state == GRANT_A) pend_a <= 1'b0;
                if (next_state == GRANT_B) pend_b <= 1'b0;
            end
        end
    end

    assign owner = last_owner;

`ifdef MUTEX_ASSERT_EN
    logic        chk_eff_a_q;
    logic        chk_eff_b_q;
    logic        chk_gnt_a_q;
    logic        chk_gnt_b_q;
    logic        chk_released;
    int unsigned chk_low_run;
    int unsigned chk_grants_a;
    int unsigned chk_grants_b;

    // Simulation checker: exclusivity, grant causality and minimum gap.
    always_ff @(posedge clk) begin
        if (gnt_a && gnt_b) begin
            $error("%0t mutex_grant_arbiter: both grants high", $time);
        end
        if (rst) begin
            chk_eff_a_q  <= 1'b0;
            chk_eff_b_q  <= 1'b0;
            chk_gnt_a_q  <= 1'b0;
            chk_gnt_b_q  <= 1'b0;
            chk_released <= 1'b0;
            chk_low_run  <= 0;
        end else begin
            chk_eff_a_q <= eff_a;
            chk_eff_b_q <= eff_b;
            chk_gnt_a_q <= gnt_a;
            chk_gnt_b_q <= gnt_b;
            if (gnt_a && !chk_gnt_a_q) begin
                chk_grants_a <= chk_grants_a + 1;
                if (!chk_eff_a_q) $error("%0t mutex_grant_arbiter: gnt_a rose without request", $time);
            end
            if (gnt_b && !chk_gnt_b_q) begin
                chk_grants_b <= chk_grants_b + 1;
                if (!chk_eff_b_q) $error("%0t mutex_grant_arbiter: gnt_b rose without request", $time);
            end
            if (((gnt_a && !chk_gnt_a_q) || (gnt_b && !chk_gnt_b_q)) && chk_released
                && (chk_low_run < 32'(GAP))) begin
                $error("%0t mutex_grant_arbiter: release gap too short", $time);
            end
            if (gnt_a || gnt_b) begin
                chk_low_run  <= 0;
                chk_released <= 1'b1;
            end else begin
                chk_low_run <= chk_low_run + 1;
            end
        end
    end

    final begin
        $display("mutex_grant_arbiter: grants to A = %0d, grants to B = %0d",
                 chk_grants_a, chk_grants_b);
    end
`endif

endmodule
`default_nettype wire
